tt_input_conditioner: RTL and testbench
=======================================

TT_INPUT_CONDITIONER -- requirements
Module: tt_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning the number of consecutive clk cycles a synchronized input must disagree with its debounced state before that state changes (10 ms at 25 MHz); legal range 2..2^20-1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port jump_raw, input, 1 bit: the asynchronous jump pushbutton, active-high.
REQ-005 The block SHALL have port reset_raw, input, 1 bit: the asynchronous game-reset pushbutton, active-high.
REQ-006 The block SHALL have port jump_ack, input, 1 bit: the game logic consumes the pending jump request.
REQ-007 The block SHALL have port jump_level, output, 1 bit: the debounced jump button level, fed to the jump physics.
REQ-008 The block SHALL have port jump_req, output, 1 bit: a sticky jump request, set on a debounced press.
REQ-009 The block SHALL have port reset_pulse, output, 1 bit: a one-cycle pulse on a debounced press of the reset button.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer; only the second flop's output SHALL be used downstream.
REQ-011 Each channel SHALL keep a debounced state register and a counter of at least 20 bits.
REQ-012 While the synchronized value equals the debounced state, the channel counter SHALL be held at 0.
REQ-013 While the synchronized value differs from the debounced state, the counter SHALL increment by 1 each cycle.
REQ-014 When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, on that same edge the debounced state SHALL take the synchronized value and the counter SHALL clear to 0.
REQ-015 Any cycle of agreement before the terminal count SHALL clear the counter; glitches shorter than DEBOUNCE_CYCLES SHALL never change the output.
REQ-016 Latency: a raw level held stable SHALL appear on jump_level exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new raw level.
REQ-017 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-018 jump_level SHALL be driven directly from the jump channel's debounced state register (registered, no combinational path from inputs).
REQ-019 jump_req SHALL be set on the edge where jump_level rises 0->1.
REQ-020 jump_req SHALL clear on the edge after jump_ack is sampled high while jump_req=1; jump_ack SHALL be ignored while jump_req=0.
REQ-021 On a simultaneous rise event and jump_ack, jump_req SHALL stay 1 (set wins).
REQ-022 A rise event while jump_req is already 1 SHALL be absorbed, i.e. no queuing.
REQ-023 reset_pulse SHALL be high for exactly one cycle, on the edge where the reset channel's debounced state rises 0->1; a debounced release SHALL produce no pulse.
REQ-024 The two channels SHALL be fully independent; simultaneous activity on both SHALL have no interaction.

Reset
REQ-025 On rst_n=0, asynchronously: all synchronizer flops, debounced states, counters, jump_level, jump_req and reset_pulse SHALL go to 0.
REQ-026 Reset asserted mid-count SHALL discard the partial count.
REQ-027 After reset deasserts with a button already held, the block SHALL treat it as a new press: a full debounce followed by jump_req set or one reset_pulse.
REQ-028 Reset SHALL be usable without a running clock.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Bench SHALL drive jump_raw 0->1 held -> jump_level=1 and jump_req=1 exactly 6 edges later, reset_pulse stays 0.
REQ-030 Bench SHALL drive jump_raw high for 3 cycles then low -> jump_level, jump_req and the counter return to 0 with no output change.
REQ-031 With jump_req=1, bench SHALL pulse jump_ack for 1 cycle -> jump_req=0 on the next edge; a second ack while jump_req=0 SHALL have no effect.
REQ-032 Bench SHALL drive jump_ack=1 on the same edge that jump_level rises -> jump_req=1 and stays 1.
REQ-033 Bench SHALL hold reset_raw high for 20 cycles -> exactly one reset_pulse, 6 edges after the first sample; release SHALL produce no pulse.
REQ-034 Bench SHALL hold jump_raw high and assert rst_n=0 at count 2 -> all outputs 0 immediately; after release, jump_level=1 DEBOUNCE_CYCLES+2 edges later.

Source files
------------

// File: rtl/tt_input_conditioner.sv
// Pushbutton front end: synchronises and debounces the jump and game-reset buttons,
// and turns debounced presses into a sticky jump request and a one-cycle reset pulse.
module tt_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic jump_raw,
  input  logic reset_raw,
  input  logic jump_ack,
  output logic jump_level,
  output logic jump_req,
  output logic reset_pulse
);

  localparam int unsigned CNT_W = 20;
  localparam int unsigned CH_JUMP = 0;
  localparam int unsigned CH_RST  = 1;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       raw;
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [1:0]       rise;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic             jump_req_q;
  logic             jump_req_d;
  logic             reset_pulse_q;
  logic             reset_pulse_d;

  assign raw = {reset_raw, jump_raw};

  // NOTE: every always_comb output gets a default before any branch, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = '0;
      if (sync2_q[ch] != state_q[ch]) begin
        // The terminal count flips the state and restarts the counter on the same edge.
        if (cnt_q[ch] == TERM_CNT) begin
          state_d[ch] = sync2_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
    rise          = state_d & ~state_q;
    // A new press wins over a simultaneous acknowledge; a press while pending is absorbed.
    jump_req_d    = rise[CH_JUMP] | (jump_req_q & ~jump_ack);
    reset_pulse_d = rise[CH_RST];
  end

  // NOTE: all state is updated with non-blocking assignments so every flop samples
  // pre-edge values, which keeps the synchroniser a genuine two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      state_q       <= '0;
      jump_req_q    <= 1'b0;
      reset_pulse_q <= 1'b0;
      // NOTE: the counters are reset too, so a press interrupted by reset restarts from zero.
      for (int ch = 0; ch < 2; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      jump_req_q    <= jump_req_d;
      reset_pulse_q <= reset_pulse_d;
      for (int ch = 0; ch < 2; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign jump_level  = state_q[CH_JUMP];
  assign jump_req    = jump_req_q;
  assign reset_pulse = reset_pulse_q;

endmodule

// File: tb/tb_tt_input_conditioner.sv
// Directed bench for tt_input_conditioner with DEBOUNCE_CYCLES=4 (press visible 6 edges
// after the input changes between edges).
module tb_tt_input_conditioner;

  localparam int unsigned DEB = 4;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst_n = 1'b0;
  logic jump_raw = 1'b0;
  logic reset_raw = 1'b0;
  logic jump_ack = 1'b0;
  logic jump_level;
  logic jump_req;
  logic reset_pulse;

  int n_vec = 0;
  int n_err = 0;

  tt_input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .jump_raw   (jump_raw),
    .reset_raw  (reset_raw),
    .jump_ack   (jump_ack),
    .jump_level (jump_level),
    .jump_req   (jump_req),
    .reset_pulse(reset_pulse)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic lvl, input logic req, input logic pls);
    check({tag, ".level"}, 32'(jump_level), 32'(lvl));
    check({tag, ".req"},   32'(jump_req),   32'(req));
    check({tag, ".pulse"}, 32'(reset_pulse), 32'(pls));
  endtask

  initial begin
    int n_pulse;
    int first_at;

    // Reset state, checked before any clock edge.
    #2;
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_outs("idle", 1'b0, 1'b0, 1'b0);

    // Clean press: visible on the 6th edge, not the 5th.
    jump_raw = 1'b1;
    tick(DEB + 1);
    check_outs("press_e5", 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("press_e6", 1'b1, 1'b1, 1'b0);

    // Ack clears on the next edge; a second ack while idle is ignored.
    jump_ack = 1'b1;
    tick();
    jump_ack = 1'b0;
    check("ack_clear", 32'(jump_req), 32'd0);
    jump_ack = 1'b1;
    tick();
    jump_ack = 1'b0;
    tick();
    check_outs("ack_idle", 1'b1, 1'b0, 1'b0);

    // Debounced release sets nothing.
    jump_raw = 1'b0;
    tick(DEB + 1);
    check_outs("rel_e5", 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("rel_e6", 1'b0, 1'b0, 1'b0);

    // Three-cycle glitch never reaches the output and the counter returns to zero.
    jump_raw = 1'b1;
    tick(3);
    jump_raw = 1'b0;
    tick(6);
    check_outs("glitch", 1'b0, 1'b0, 1'b0);
    check("glitch_cnt", 32'(dut.cnt_q[0]), 32'd0);

    // Ack on the very edge the level rises: set wins.
    jump_raw = 1'b1;
    tick(DEB + 1);
    jump_ack = 1'b1;
    tick();
    jump_ack = 1'b0;
    check_outs("setwins", 1'b1, 1'b1, 1'b0);
    tick(2);
    check("setwins_hold", 32'(jump_req), 32'd1);

    // Second press while pending is absorbed: one ack clears everything.
    jump_raw = 1'b0;
    tick(DEB + 2);
    jump_raw = 1'b1;
    tick(DEB + 2);
    check_outs("absorb", 1'b1, 1'b1, 1'b0);
    jump_ack = 1'b1;
    tick();
    jump_ack = 1'b0;
    tick(2);
    check("absorb_clear", 32'(jump_req), 32'd0);
    jump_raw = 1'b0;
    tick(DEB + 2);
    check("absorb_rel", 32'(jump_level), 32'd0);

    // Reset button held 20 cycles alongside a jump press: one pulse on edge 6, no interaction.
    n_pulse  = 0;
    first_at = 0;
    reset_raw = 1'b1;
    jump_raw  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (reset_pulse) begin
        n_pulse++;
        if (first_at == 0) first_at = i;
      end
      if (i == DEB + 2) check_outs("both_e6", 1'b1, 1'b1, 1'b1);
    end
    check("rpulse_count", 32'(n_pulse), 32'd1);
    check("rpulse_edge", 32'(first_at), 32'(DEB + 2));
    n_pulse = 0;
    reset_raw = 1'b0;
    jump_raw  = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (reset_pulse) n_pulse++;
    end
    check("rrel_pulses", 32'(n_pulse), 32'd0);
    check_outs("both_rel", 1'b0, 1'b1, 1'b0);
    jump_ack = 1'b1;
    tick();
    jump_ack = 1'b0;
    check("both_ack", 32'(jump_req), 32'd0);

    // Reset mid-count with the clock stopped, then a fresh full debounce.
    jump_raw = 1'b1;
    tick(4);
    check("midcnt", 32'(dut.cnt_q[0]), 32'd2);
    clk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midcnt_rst", 32'(dut.cnt_q[0]), 32'd0);
    check_outs("noclk_rst", 1'b0, 1'b0, 1'b0);
    #20;
    rst_n  = 1'b1;
    clk_en = 1'b1;
    tick(DEB + 1);
    check_outs("post_e5", 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("post_e6", 1'b1, 1'b1, 1'b0);

    // Asynchronous reset between edges clears asserted outputs immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 1'b0);
    tick(2);
    check_outs("held_rst", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
